tag_rx_symb_accum: RTL and testbench

- Integrate-and-dump stage directly downstream of usrp_tag_chip_tag_rx_ctrl.
- Consumes the baseband I/Q stream (irx_out_bb/qrx_out_bb, rx_valid) and the sync strobe (peak_detect_stb).
- After each sync, sums I and Q separately over NSYMB consecutive windows of NSIG valid samples.
- Emits one accumulated I/Q pair per symbol, plus an end-of-frame strobe, to the decision/logging logic.

---
 rtl/tag_rx_symb_accum.sv | 157 +++++++++++++++
 tb/tb_tag_rx_symb_accum.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_rx_symb_accum.sv
// Integrate-and-dump of the baseband I/Q stream: after each sync, sums NSYMB windows of NSIG valid samples.
// Optional: define TAG_RX_ACCUM_RESYNC_EN to let a sync_stb during accumulation restart the frame.

module tag_rx_symb_accum_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 36
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  take,
  input  logic                  first,
  input  logic                  dump,
  input  logic [DATA_WIDTH-1:0] smp,
  output logic [ACC_WIDTH-1:0]  sum
);
  logic [ACC_WIDTH-1:0] acc, ext, acc_nxt;

  assign ext     = {{(ACC_WIDTH-DATA_WIDTH){smp[DATA_WIDTH-1]}}, smp};
  // Sample 0 loads directly so back-to-back symbols need no clear cycle.
  assign acc_nxt = first ? ext : acc + ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      sum <= '0;
    end else begin
      if (take) acc <= acc_nxt;
      if (dump) sum <= acc_nxt;
    end
  end
endmodule

module tag_rx_symb_accum #(
  parameter int DATA_WIDTH  = 16,
  parameter int NSIG        = 262144,
  parameter int NSYMB       = 4,
  parameter int NSYMB_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                run,
  input  logic                                sync_stb,
  input  logic                                in_valid,
  input  logic [DATA_WIDTH-1:0]               i_in,
  input  logic [DATA_WIDTH-1:0]               q_in,
  output logic                                out_valid,
  output logic [DATA_WIDTH+$clog2(NSIG):0]    i_acc,
  output logic [DATA_WIDTH+$clog2(NSIG):0]    q_acc,
  output logic [NSYMB_WIDTH-1:0]              symb_idx,
  output logic                                frame_done,
  output logic [1:0]                          state
);
  localparam int ACC_WIDTH = DATA_WIDTH + $clog2(NSIG) + 1;
  localparam int SW        = $clog2(NSIG);
  localparam int NUM_LANES = 2;
  localparam logic [SW-1:0]          LAST_SAMP = SW'(NSIG - 1);
  localparam logic [NSYMB_WIDTH-1:0] LAST_SYMB = NSYMB_WIDTH'(NSYMB - 1);
`ifdef TAG_RX_ACCUM_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, ACCUM = 2'd2} state_t;

  state_t                  st, st_nxt;
  logic [SW-1:0]           samp_cnt, eff_samp;
  logic [NSYMB_WIDTH-1:0]  symb_cnt, eff_symb;
  logic                    restart, take, first, last, frame_end;

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] smp;
  logic [NUM_LANES-1:0][ACC_WIDTH-1:0]  sum;

  assign state = st;

  // A sync-triggered start makes the current sample (if valid) sample 0 of symbol 0.
  always_comb begin
    restart   = run && sync_stb && (st == ARMED || (RESYNC && st == ACCUM));
    take      = run && in_valid && (restart || st == ACCUM);
    eff_samp  = restart ? '0 : samp_cnt;
    eff_symb  = restart ? '0 : symb_cnt;
    first     = (eff_samp == '0);
    last      = take && (eff_samp == LAST_SAMP);
    frame_end = last && (eff_symb == LAST_SYMB);
  end

  always_comb begin
    st_nxt = st;
    if (!run) st_nxt = IDLE;
    else begin
      case (st)
        IDLE:    st_nxt = ARMED;
        ARMED:   if (sync_stb) st_nxt = ACCUM;
        ACCUM:   if (frame_end) st_nxt = ARMED;
        default: st_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st <= IDLE;
    else          st <= st_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      samp_cnt <= '0;
      symb_cnt <= '0;
    end else if (!run || st == IDLE) begin
      samp_cnt <= '0;
      symb_cnt <= '0;
    end else if (take) begin
      if (last) begin
        samp_cnt <= '0;
        symb_cnt <= frame_end ? '0 : eff_symb + 1'b1;
      end else begin
        samp_cnt <= eff_samp + 1'b1;
        symb_cnt <= eff_symb;
      end
    end else if (restart) begin
      samp_cnt <= '0;
      symb_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      symb_idx   <= '0;
    end else begin
      out_valid  <= last;
      frame_done <= frame_end;
      if (last) symb_idx <= eff_symb;
    end
  end

  assign smp = {q_in, i_in};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    tag_rx_symb_accum_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .take    (take),
      .first   (first),
      .dump    (last),
      .smp     (smp[l]),
      .sum     (sum[l])
    );
  end

  assign i_acc = sum[0];
  assign q_acc = sum[1];
endmodule

// File: tb/tb_tag_rx_symb_accum.sv
// Bench for tag_rx_symb_accum: frame table, directed corner sequences, random run vs. a queue-based model.
module tb_tag_rx_symb_accum;
  localparam int DW = 16, NSIG = 8, NSYMB = 4, NSW = 16;
  localparam int AW = DW + $clog2(NSIG) + 1;
`ifdef TAG_RX_ACCUM_RESYNC_EN
  localparam bit RESYNC_TB = 1'b1;
`else
  localparam bit RESYNC_TB = 1'b0;
`endif

  logic clk = 1'b0, reset_n = 1'b0, run = 1'b0, sync_stb = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] i_in = '0, q_in = '0;
  logic out_valid, frame_done;
  logic [AW-1:0] i_acc, q_acc;
  logic [NSW-1:0] symb_idx;
  logic [1:0] state;

  int errs = 0, checks = 0;

  tag_rx_symb_accum #(.DATA_WIDTH(DW), .NSIG(NSIG), .NSYMB(NSYMB), .NSYMB_WIDTH(NSW)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .sync_stb(sync_stb), .in_valid(in_valid),
    .i_in(i_in), .q_in(q_in), .out_valid(out_valid), .i_acc(i_acc), .q_acc(q_acc),
    .symb_idx(symb_idx), .frame_done(frame_done), .state(state));

  always #5 clk = ~clk;

  typedef struct {
    int     i;
    int     q;
    bit     toggle;
    longint ei;
    longint eq;
  } frame_vec_t;

  frame_vec_t vecs[4];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit s, input bit v, input int iv, input int qv);
    run = r; sync_stb = s; in_valid = v; i_in = DW'(iv); q_in = DW'(qv);
  endtask

  // Full frame from ARMED: checks every dump's value, index, timing and frame_done.
  task automatic do_frame(input frame_vec_t v);
    for (int s = 0; s < NSYMB; s++) begin
      for (int k = 0; k < NSIG; k++) begin
        drive(1, (s == 0 && k == 0), 1, v.i, v.q);
        step();
        chk("frm_ov", out_valid, (k == NSIG - 1));
        if (k == NSIG - 1) begin
          chk("frm_i", $signed(i_acc), v.ei);
          chk("frm_q", $signed(q_acc), v.eq);
          chk("frm_idx", symb_idx, s);
          chk("frm_fd", frame_done, (s == NSYMB - 1));
        end
        if (v.toggle) begin
          drive(1, 0, 0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
          step();
          chk("frm_gap_ov", out_valid, 0);
        end
      end
    end
    drive(1, 0, 0, 0, 0);
    chk("frm_state_armed", state, 1);
  endtask

  // Feeds n valid samples of constant value, no sync, checking that no dump appears.
  task automatic feed_quiet(input int n, input int iv, input int qv);
    for (int k = 0; k < n; k++) begin
      drive(1, 0, 1, iv, qv);
      step();
      chk("quiet_ov", out_valid, 0);
    end
  endtask

  initial begin
    vecs[0] = '{i: 100,    q: -50,   toggle: 1'b0, ei: 800,     eq: -400};
    vecs[1] = '{i: -32768, q: 32767, toggle: 1'b0, ei: -262144, eq: 262136};
    vecs[2] = '{i: 100,    q: -50,   toggle: 1'b1, ei: 800,     eq: -400};
    vecs[3] = '{i: 7,      q: -3,    toggle: 1'b1, ei: 56,      eq: -24};

    // Reset state
    #12;
    chk("rst_state", state, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_i", i_acc, 0);
    chk("rst_q", q_acc, 0);
    chk("rst_idx", symb_idx, 0);
    reset_n = 1'b1;

    // Run without sync: parks in ARMED, samples ignored
    for (int c = 0; c < 10; c++) begin
      drive(1, 0, 1, 1234, -99);
      step();
      chk("nosync_state", state, 1);
      chk("nosync_ov", out_valid, 0);
    end
    chk("nosync_i", i_acc, 0);

    foreach (vecs[n]) do_frame(vecs[n]);

    // run dropped mid symbol 2
    drive(1, 1, 1, 1, -1); step();
    drive(1, 0, 1, 1, -1);
    for (int k = 1; k < 2 * NSIG; k++) begin
      step();
      if (k == NSIG - 1 || k == 2 * NSIG - 1) chk("drop_pre_ov", out_valid, 1);
    end
    chk("drop_pre_idx", symb_idx, 1);
    chk("drop_pre_i", $signed(i_acc), 8);
    feed_quiet(5, 4, 4);
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 1, 4, 4);
      step();
      chk("drop_ov", out_valid, 0);
      chk("drop_state", state, 0);
    end
    chk("drop_hold_i", $signed(i_acc), 8);
    chk("drop_hold_q", $signed(q_acc), -8);
    drive(1, 0, 0, 0, 0); step();
    chk("rerun_state", state, 1);
    drive(1, 1, 1, 3, -2); step();
    feed_quiet(NSIG - 2, 3, -2);
    drive(1, 0, 1, 3, -2); step();
    chk("rerun_ov", out_valid, 1);
    chk("rerun_idx", symb_idx, 0);
    chk("rerun_i", $signed(i_acc), 24);
    chk("rerun_q", $signed(q_acc), -16);

    // run falls on the final sample of a symbol: no dump
    feed_quiet(NSIG - 1, 9, 9);
    drive(0, 0, 1, 9, 9); step();
    chk("lastfall_ov", out_valid, 0);
    chk("lastfall_state", state, 0);
    chk("lastfall_i", $signed(i_acc), 24);

    // sync_stb at sample 3 of symbol 1
    drive(1, 0, 0, 0, 0); step();
    drive(1, 1, 1, 1, -1); step();
    feed_quiet(NSIG - 2, 1, -1);
    drive(1, 0, 1, 1, -1); step();
    chk("rs_sym0_ov", out_valid, 1);
    feed_quiet(3, 1, -1);
    for (int k = 0; k < NSIG; k++) begin
      drive(1, (k == 0), 1, 2, -2);
      step();
      if (RESYNC_TB) begin
        chk("rs_ov", out_valid, (k == NSIG - 1));
        if (k == NSIG - 1) begin
          chk("rs_idx", symb_idx, 0);
          chk("rs_i", $signed(i_acc), 16);
          chk("rs_q", $signed(q_acc), -16);
        end
      end else begin
        chk("nors_ov", out_valid, (k == 4));
        if (k == 4) begin
          chk("nors_idx", symb_idx, 1);
          chk("nors_i", $signed(i_acc), 13);
          chk("nors_q", $signed(q_acc), -13);
        end
      end
    end
    drive(0, 0, 0, 0, 0); step();

    // Asynchronous reset mid-frame clears everything immediately
    drive(1, 0, 0, 0, 0); step();
    drive(1, 1, 1, 5, 5); step();
    feed_quiet(NSIG - 2, 5, 5);
    drive(1, 0, 1, 5, 5); step();
    chk("ar_pre_i", $signed(i_acc), 40);
    feed_quiet(3, 5, 5);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_state", state, 0);
    chk("ar_i", i_acc, 0);
    chk("ar_idx", symb_idx, 0);
    drive(0, 0, 0, 0, 0);
    #3 reset_n = 1'b1;

    // Random stimulus against a sample-queue model
    begin
      int     m_mode = 0, m_sym = 0;
      int     qi[$], qq[$];
      longint e_i = 0, e_q = 0;
      int     e_idx = 0;
      bit     e_ov, e_fd;
      bit     r, s, v;
      logic signed [DW-1:0] ri, rq;
      for (int c = 0; c < 3000; c++) begin
        r  = ($urandom_range(0, 199) != 0);
        s  = ($urandom_range(0, 59) == 0);
        v  = ($urandom_range(0, 2) != 0);
        ri = DW'($urandom);
        rq = DW'($urandom);
        drive(r, s, v, int'(ri), int'(rq));
        step();
        e_ov = 1'b0; e_fd = 1'b0;
        if (!r) begin
          m_mode = 0; qi.delete(); qq.delete();
        end else if (m_mode == 0) begin
          m_mode = 1;
        end else begin
          if (s && (m_mode == 1 || (RESYNC_TB && m_mode == 2))) begin
            m_mode = 2; m_sym = 0; qi.delete(); qq.delete();
          end
          if (m_mode == 2 && v) begin
            qi.push_back(int'(ri)); qq.push_back(int'(rq));
          end
          if (qi.size() == NSIG) begin
            e_i = 0; e_q = 0;
            foreach (qi[n]) begin e_i += qi[n]; e_q += qq[n]; end
            e_ov = 1'b1; e_idx = m_sym;
            qi.delete(); qq.delete();
            if (m_sym == NSYMB - 1) begin e_fd = 1'b1; m_mode = 1; m_sym = 0; end
            else m_sym++;
          end
        end
        chk("rnd_ov", out_valid, e_ov);
        chk("rnd_fd", frame_done, e_fd);
        chk("rnd_i", $signed(i_acc), e_i);
        chk("rnd_q", $signed(q_acc), e_q);
        chk("rnd_idx", symb_idx, e_idx);
        chk("rnd_state", state, m_mode);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
